// File: rtl/uart_pkg.sv
// Shared definitions for the parity UART transmitter: FSM encoding and line levels.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam int   FRAME_DATA_BITS = 8;
   localparam logic LINE_IDLE       = 1'b1;
   localparam logic START_BIT       = 1'b0;
   localparam logic STOP_BIT        = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period tick counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last tick.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic bit_done
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign bit_done = en && (count == LAST);

endmodule

// File: rtl/parity_uart_tx.sv
// UART frame transmitter with parity: start, 8 data bits LSB-first, parity, stop.
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | start bit on line
// DATA   | shifting out data bits, LSB first
// PARITY | parity bit on line
// STOP   | stop bit on line, then back to IDLE
module parity_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy,
   output logic       parity_out
);

   localparam int                BCW      = $clog2(FRAME_DATA_BITS);
   localparam logic [BCW-1:0]    LAST_BIT = BCW'(FRAME_DATA_BITS - 1);

   state_t                       state;
   logic [FRAME_DATA_BITS-1:0]   shift;
   logic [BCW-1:0]               bit_cnt;
   logic                         bit_done;
   logic                         parity_next;

   assign parity_next = (^in_data) ^ PARITY_ODD;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .en       (state != ST_IDLE),
      .clr      (state == ST_IDLE),
      .bit_done (bit_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         shift      <= '0;
         bit_cnt    <= '0;
         tx         <= LINE_IDLE;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         parity_out <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // The start bit goes on the line at the accept edge itself.
               if (in_valid && in_ready) begin
                  shift      <= in_data;
                  parity_out <= parity_next;
                  tx         <= START_BIT;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_START;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  tx      <= shift[0];
                  shift   <= shift >> 1;
                  bit_cnt <= '0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  if (bit_cnt == LAST_BIT) begin
                     tx    <= parity_out;
                     state <= ST_PARITY;
                  end else begin
                     tx      <= shift[0];
                     shift   <= shift >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  tx    <= STOP_BIT;
                  state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  tx       <= LINE_IDLE;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_uart_tx.sv
// Bench for parity_uart_tx: even and odd parity instances against a frame-level reference.
module tb_parity_uart_tx;

   localparam int CPB = 4;
   localparam int FRAME_CYC = 11 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       valid_e = 1'b0, valid_o = 1'b0;
   logic       ready_e, tx_e, busy_e, par_e;
   logic       ready_o, tx_o, busy_o, par_o;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   parity_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_e),
      .in_ready(ready_e), .tx(tx_e), .busy(busy_e), .parity_out(par_e)
   );

   parity_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_o),
      .in_ready(ready_o), .tx(tx_o), .busy(busy_o), .parity_out(par_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Expected line bits of one frame, index 0 = start bit.
   function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit odd);
      logic [10:0] b;
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      b[0]   = 1'b0;
      b[8:1] = d;
      b[9]   = ((ones % 2) == 1) ^ odd;
      b[10]  = 1'b1;
      return b;
   endfunction

   function automatic logic tx_of(input int s);    return s ? tx_o    : tx_e;    endfunction
   function automatic logic rdy_of(input int s);   return s ? ready_o : ready_e; endfunction
   function automatic logic busy_of(input int s);  return s ? busy_o  : busy_e;  endfunction
   function automatic logic par_of(input int s);   return s ? par_o   : par_e;   endfunction

   task automatic set_valid(input int s, input logic v);
      if (s != 0) valid_o = v;
      else        valid_e = v;
   endtask

   task automatic chk_idle(input int s, input string tag);
      chk({tag, "_tx"},    tx_of(s),   1'b1);
      chk({tag, "_ready"}, rdy_of(s),  1'b1);
      chk({tag, "_busy"},  busy_of(s), 1'b0);
   endtask

   // Offer a byte, wait for accept, then check every cycle of the frame.
   task automatic send(input int s, input logic [7:0] d, input bit hold,
                       input bit glitch, input logic [7:0] gdata, output int acc_cyc);
      logic [10:0] exp;
      int n = 0;
      in_data = d;
      set_valid(s, 1'b1);
      while (!rdy_of(s) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk("accept_timeout", 32'd0, 32'd1);
         set_valid(s, 1'b0);
         acc_cyc = cyc;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (!hold) set_valid(s, 1'b0);
      exp = frame_bits(d, s != 0);
      for (int k = 0; k < FRAME_CYC; k++) begin
         @(negedge clk);
         if (glitch && k == 10) in_data = gdata;
         chk($sformatf("tx_bit%0d", k / CPB), tx_of(s), exp[k / CPB]);
         chk("busy_frame", busy_of(s), 1'b1);
      end
      chk("parity_out", par_of(s), exp[9]);
      @(negedge clk);
      chk_idle(s, "post_frame");
      chk("parity_hold", par_of(s), exp[9]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c1, c2, dummy;
      // 1. reset and idle
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            chk_idle(s, "reset");
            chk("reset_parity", par_of(s), 1'b0);
         end
      end

      // 2. even parity A5, 3. odd parity 07
      send(0, 8'hA5, 1'b0, 1'b0, 8'h00, dummy);
      send(1, 8'h07, 1'b0, 1'b0, 8'h00, dummy);

      // 4. in_valid held high across two bytes
      send(0, 8'h01, 1'b1, 1'b0, 8'h00, c1);
      send(0, 8'h80, 1'b0, 1'b0, 8'h00, c2);
      chk("b2b_period", c2 - c1, FRAME_CYC + 1);

      // 5. reset mid-frame
      @(negedge clk);
      in_data = 8'h01;
      valid_e = 1'b1;
      @(posedge clk);
      #1 valid_e = 1'b0;
      repeat (20) @(negedge clk);
      chk("pre_rst_busy", busy_e, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_idle(0, "mid_rst");
      chk("mid_rst_parity", par_e, 1'b0);
      send(0, 8'hC3, 1'b0, 1'b0, 8'h00, dummy);

      // rst and accept on the same edge: nothing accepted
      @(negedge clk);
      rst = 1'b1;
      in_data = 8'h01;
      valid_e = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      valid_e = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_idle(0, "rst_vs_accept");
         chk("rst_vs_accept_parity", par_e, 1'b0);
      end

      // 6. in_data changes mid-frame
      send(0, 8'h3C, 1'b0, 1'b1, 8'hFF, dummy);

      // randomized frames on both parities
      for (int i = 0; i < 16; i++) begin
         int s;
         logic [7:0] d, g;
         s = $urandom_range(0, 1);
         d = 8'($urandom);
         g = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(s, d, 1'b0, $urandom_range(0, 1) == 1, g, dummy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
